// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, header
// field positions, memory-target encoding and the decoded header payload.
package loader_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned RUN_W  = 32;

  // Header word field positions
  localparam int unsigned TGT_BIT  = 31;
  localparam int unsigned LAST_BIT = 30;
  localparam int unsigned CNT_MSB  = 29;
  localparam int unsigned CNT_LSB  = 15;
  localparam int unsigned ADDR_MSB = 14;

  localparam logic TGT_INSTR = 1'b0;
  localparam logic TGT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_DATA    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  typedef struct packed {
    logic             tgt;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [14:0]      base;
  } hdr_t;

  // Split a stream word into header fields
  function automatic hdr_t parse_hdr(input logic [DATA_W-1:0] w);
    hdr_t h;
    h.tgt  = w[TGT_BIT];
    h.last = w[LAST_BIT];
    h.cnt  = w[CNT_MSB:CNT_LSB];
    h.base = w[ADDR_MSB:0];
    return h;
  endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: streams a header/payload word sequence into the instruction
// or data BRAM port B, holds the CPU in reset while loading, releases it after
// RELEASE_DELAY cycles and counts run cycles until the CPU raises its stop flag.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   s_data/s_valid/s_ready     valid/ready word stream (header or payload)
//   instr_init_*/data_init_*   BRAM port-B write interfaces (addr, din, en, we)
//   cpu_reset_o                active-high CPU reset
//   cpu_stop_i, restart_i      CPU stop flag, return-to-load pulse
//   loading_o, done_o          status (loading / halted)
//   run_cycles_o               saturating count of cycles spent running
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W        = 15,
  parameter int unsigned RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] instr_init_addr,
  output logic [DATA_W-1:0] instr_init_din,
  output logic              instr_init_en,
  output logic [WE_W-1:0]   instr_init_we,
  output logic [ADDR_W-1:0] data_init_addr,
  output logic [DATA_W-1:0] data_init_din,
  output logic              data_init_en,
  output logic [WE_W-1:0]   data_init_we,
  output logic              cpu_reset_o,
  input  logic              cpu_stop_i,
  input  logic              restart_i,
  output logic              loading_o,
  output logic              done_o,
  output logic [RUN_W-1:0]  run_cycles_o
);

  localparam int unsigned REL_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  state_e            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;

  logic              s_ready_q, s_ready_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [DATA_W-1:0] i_din_q, i_din_d, d_din_q, d_din_d;
  logic              i_en_q, i_en_d, d_en_q, d_en_d;
  logic [WE_W-1:0]   i_we_q, i_we_d, d_we_q, d_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;

  hdr_t hdr;
  logic accept;

  assign hdr    = parse_hdr(s_data);
  // s_ready is registered, so acceptance depends only on the registered handshake
  assign accept = s_valid && s_ready_q;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    last_d    = last_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    rel_cnt_d = rel_cnt_q;
    run_cnt_d = run_cnt_q;
    i_addr_d  = i_addr_q;
    i_din_d   = i_din_q;
    i_en_d    = 1'b0;
    i_we_d    = '0;
    d_addr_d  = d_addr_q;
    d_din_d   = d_din_q;
    d_en_d    = 1'b0;
    d_we_d    = '0;

    case (state_q)
      ST_HDR: begin
        if (accept) begin
          tgt_d     = hdr.tgt;
          last_d    = hdr.last;
          rem_d     = hdr.cnt;
          addr_d    = ADDR_W'(hdr.base);
          rel_cnt_d = '0;
          if (hdr.cnt != '0) begin
            state_d = ST_DATA;
          end else if (hdr.last) begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (tgt_q == TGT_INSTR) begin
            i_en_d   = 1'b1;
            i_we_d   = '1;
            i_addr_d = addr_q;
            i_din_d  = s_data;
          end else if (tgt_q == TGT_DATA) begin
            d_en_d   = 1'b1;
            d_we_d   = '1;
            d_addr_d = addr_q;
            d_din_d  = s_data;
          end
          // Address wraps naturally at 2^ADDR_W
          addr_d    = addr_q + ADDR_W'(1);
          rem_d     = rem_q - CNT_W'(1);
          rel_cnt_d = '0;
          if (rem_q == CNT_W'(1)) begin
            state_d = last_q ? ST_RELEASE : ST_HDR;
          end
        end
      end
      ST_RELEASE: begin
        if (rel_cnt_q == REL_W'(RELEASE_DELAY - 1)) begin
          state_d = ST_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
        end
      end
      ST_RUN: begin
        if (run_cnt_q != '1) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end
        // restart has priority over a simultaneous stop
        if (restart_i) begin
          state_d   = ST_HDR;
          run_cnt_d = '0;
        end else if (cpu_stop_i) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (restart_i) begin
          state_d   = ST_HDR;
          run_cnt_d = '0;
        end
      end
      default: state_d = ST_HDR;
    endcase

    // Status outputs are registered from the next state so they align with it
    s_ready_d   = (state_d == ST_HDR) || (state_d == ST_DATA);
    loading_d   = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_RELEASE);
    done_d      = (state_d == ST_HALT);
    cpu_reset_d = !((state_d == ST_RUN) || (state_d == ST_HALT));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HDR;
      tgt_q       <= 1'b0;
      last_q      <= 1'b0;
      rem_q       <= '0;
      addr_q      <= '0;
      rel_cnt_q   <= '0;
      run_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      i_addr_q    <= '0;
      i_din_q     <= '0;
      i_en_q      <= 1'b0;
      i_we_q      <= '0;
      d_addr_q    <= '0;
      d_din_q     <= '0;
      d_en_q      <= 1'b0;
      d_we_q      <= '0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      last_q      <= last_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      rel_cnt_q   <= rel_cnt_d;
      run_cnt_q   <= run_cnt_d;
      s_ready_q   <= s_ready_d;
      i_addr_q    <= i_addr_d;
      i_din_q     <= i_din_d;
      i_en_q      <= i_en_d;
      i_we_q      <= i_we_d;
      d_addr_q    <= d_addr_d;
      d_din_q     <= d_din_d;
      d_en_q      <= d_en_d;
      d_we_q      <= d_we_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign instr_init_addr = i_addr_q;
  assign instr_init_din  = i_din_q;
  assign instr_init_en   = i_en_q;
  assign instr_init_we   = i_we_q;
  assign data_init_addr  = d_addr_q;
  assign data_init_din   = d_din_q;
  assign data_init_en    = d_en_q;
  assign data_init_we    = d_we_q;
  assign cpu_reset_o     = cpu_reset_q;
  assign loading_o       = loading_q;
  assign done_o          = done_q;
  assign run_cycles_o    = run_cnt_q;

endmodule
